// File: rtl/flag_stk_pkg.sv
// Shared types for the status-flag register and its shadow stack.
// Flag index constants, the stack operation encoding and the level-width helper.
package flag_stk_pkg;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;

    typedef enum logic [1:0] {
        STK_NOP,
        STK_PUSH,
        STK_POP,
        STK_XCHG
    } stk_op_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/flag_lifo.sv
// LIFO of saved flag words: DEPTH entries, stack pointer, full/empty status.
// Supports push, pop and an in-place exchange of the top entry.
module flag_lifo
    import flag_stk_pkg::*;
#(
    parameter int NUM_FLAGS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  stk_op_t                   op,
    input  logic [NUM_FLAGS-1:0]      wr_data,
    output logic [NUM_FLAGS-1:0]      top_data,
    output logic [lvl_w(DEPTH)-1:0]   lvl,
    output logic                      full,
    output logic                      empty
);

    localparam int LW = lvl_w(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LW-1:0]        lvl_reg;
    logic [LW-1:0]        lvl_next;
    logic [IW-1:0]        top_idx;
    logic [IW-1:0]        wr_idx;
    logic                 wr_en;
    logic [NUM_FLAGS-1:0] entry_q [DEPTH];

    assign full     = (lvl_reg == LW'(DEPTH));
    assign empty    = (lvl_reg == '0);
    assign lvl      = lvl_reg;
    // Index is forced to 0 when empty so the read never leaves the array.
    assign top_idx  = empty ? '0 : IW'(lvl_reg - LW'(1));
    assign top_data = entry_q[top_idx];

    always_comb begin
        lvl_next = lvl_reg;
        wr_en    = 1'b0;
        wr_idx   = IW'(lvl_reg);
        case (op)
            STK_PUSH: begin
                if (!full) begin
                    wr_en    = 1'b1;
                    lvl_next = lvl_reg + LW'(1);
                end
            end
            STK_POP: begin
                if (!empty) begin
                    lvl_next = lvl_reg - LW'(1);
                end
            end
            STK_XCHG: begin
                if (!empty) begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_reg <= '0;
        end else begin
            lvl_reg <= lvl_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [NUM_FLAGS-1:0] data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
            end else if (wr_en && (wr_idx == IW'(gi))) begin
                data_reg <= wr_data;
            end
        end

        assign entry_q[gi] = data_reg;
    end

endmodule

// File: rtl/flag_shadow_stack.sv
// CPU status-flag register with per-flag set/clear/load and a LIFO shadow stack.
// Define FLG_STK_ERR_EN to build the sticky {underflow, overflow} error bits.
module flag_shadow_stack
    import flag_stk_pkg::*;
#(
    parameter int NUM_FLAGS = 2,
    parameter int DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_FLAGS-1:0]      flg_set,
    input  logic [NUM_FLAGS-1:0]      flg_clr,
    input  logic [NUM_FLAGS-1:0]      flg_ld,
    input  logic [NUM_FLAGS-1:0]      flg_in,
    input  logic                      flg_push,
    input  logic                      flg_pop,
    output logic [NUM_FLAGS-1:0]      flags,
    output logic [lvl_w(DEPTH)-1:0]   stk_lvl,
    output logic                      stk_full,
    output logic                      stk_empty,
    output logic [1:0]                stk_err
);

    stk_op_t              op;
    logic                 pop_ok;
    logic [NUM_FLAGS-1:0] top_data;
    logic [NUM_FLAGS-1:0] flags_reg;

    // Push+pop on an empty stack degrades to a plain push.
    always_comb begin
        op = STK_NOP;
        case ({flg_push, flg_pop})
            2'b10:   op = STK_PUSH;
            2'b01:   op = STK_POP;
            2'b11:   op = stk_empty ? STK_PUSH : STK_XCHG;
            default: op = STK_NOP;
        endcase
    end

    assign pop_ok = ((op == STK_POP) || (op == STK_XCHG)) && !stk_empty;

    flag_lifo #(
        .NUM_FLAGS (NUM_FLAGS),
        .DEPTH     (DEPTH)
    ) u_lifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .wr_data  (flags_reg),
        .top_data (top_data),
        .lvl      (stk_lvl),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_flag
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                flags_reg[gi] <= 1'b0;
            end else if (flg_clr[gi]) begin
                flags_reg[gi] <= 1'b0;
            end else if (flg_set[gi]) begin
                flags_reg[gi] <= 1'b1;
            end else if (pop_ok) begin
                flags_reg[gi] <= top_data[gi];
            end else if (flg_ld[gi]) begin
                flags_reg[gi] <= flg_in[gi];
            end
        end
    end

    assign flags = flags_reg;

`ifdef FLG_STK_ERR_EN
    logic [1:0] err_reg;
    logic       overflow;
    logic       underflow;

    assign overflow  = (op == STK_PUSH) && stk_full;
    assign underflow = flg_pop && stk_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 2'b00;
        end else begin
            err_reg <= err_reg | {underflow, overflow};
        end
    end

    assign stk_err = err_reg;
`else
    assign stk_err = 2'b00;
`endif

endmodule
